// File: rtl/fpu_pkg.sv
// Shared types for the add/sub issue scheduler: requester id and the tracker
// entry that follows each op through the external pipeline.
package fpu_pkg;

  localparam int unsigned NUM_REQ    = 2;
  localparam int unsigned TAG_W_DFLT = 4;

  typedef logic req_id_t;

  typedef struct packed {
    logic                  valid;
    req_id_t               req_id;
    logic [TAG_W_DFLT-1:0] tag;
  } track_entry_t;

endpackage

// File: rtl/addsub_res_fifo.sv
// First-word-fall-through result FIFO, one per requester.
// Ports:
//   clk, rst             clock, synchronous active-high reset
//   push, push_data/tag  write a result (never presented while full)
//   pop                  consume the head; ignored while empty
//   valid, data, tag     head entry, held until popped
//   count                current occupancy (0..RES_DEPTH)
module addsub_res_fifo #(
  parameter int unsigned NUM_BITS  = 16,
  parameter int unsigned TAG_W     = 4,
  parameter int unsigned RES_DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         push,
  input  logic [NUM_BITS-1:0]          push_data,
  input  logic [TAG_W-1:0]             push_tag,
  input  logic                         pop,
  output logic                         valid,
  output logic [NUM_BITS-1:0]          data,
  output logic [TAG_W-1:0]             tag,
  output logic [$clog2(RES_DEPTH):0]   count
);

  localparam int unsigned PTR_W = $clog2(RES_DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [NUM_BITS-1:0] mem_data [RES_DEPTH];
  logic [TAG_W-1:0]    mem_tag  [RES_DEPTH];
  logic [PTR_W-1:0]    wr_ptr;
  logic [PTR_W-1:0]    rd_ptr;
  logic                do_pop;

  assign valid  = (count != '0);
  assign data   = mem_data[rd_ptr];
  assign tag    = mem_tag[rd_ptr];
  assign do_pop = pop & valid;

  // Storage, pointers (wrap naturally, depth is a power of 2) and occupancy.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < int'(RES_DEPTH); i++) begin
        mem_data[i] <= '0;
        mem_tag[i]  <= '0;
      end
    end else begin
      if (push) begin
        mem_data[wr_ptr] <= push_data;
        mem_tag[wr_ptr]  <= push_tag;
        wr_ptr           <= wr_ptr + PTR_W'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      case ({push, do_pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/addsub_issue_sched.sv
// Shares one fixed-latency add/sub pipeline between two requesters.
// Round-robin arbitration gated by per-requester credits, issue register,
// in-flight tracker and per-requester result FIFOs.
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   req_valid/ready               per-requester request handshake
//   req_a/b/sub/tag               per-requester operands, op select, tag
//   issue_valid/a/b               registered op to the pipeline (b sign adjusted)
//   res_data                      pipeline result, sampled at tracker exit
//   out_valid/ready/data/tag      per-requester result FIFO head
//   busy                          any op in flight or any result pending
module addsub_issue_sched
  import fpu_pkg::*;
#(
  parameter int unsigned NUM_BITS  = 16,
  parameter int unsigned TAG_W     = TAG_W_DFLT,
  parameter int unsigned PIPE_LAT  = 3,
  parameter int unsigned RES_DEPTH = 4
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic [NUM_REQ-1:0]                 req_valid,
  output logic [NUM_REQ-1:0]                 req_ready,
  input  logic [NUM_REQ-1:0][NUM_BITS-1:0]   req_a,
  input  logic [NUM_REQ-1:0][NUM_BITS-1:0]   req_b,
  input  logic [NUM_REQ-1:0]                 req_sub,
  input  logic [NUM_REQ-1:0][TAG_W-1:0]      req_tag,
  output logic                               issue_valid,
  output logic [NUM_BITS-1:0]                issue_a,
  output logic [NUM_BITS-1:0]                issue_b,
  input  logic [NUM_BITS-1:0]                res_data,
  output logic [NUM_REQ-1:0]                 out_valid,
  input  logic [NUM_REQ-1:0]                 out_ready,
  output logic [NUM_REQ-1:0][NUM_BITS-1:0]   out_data,
  output logic [NUM_REQ-1:0][TAG_W-1:0]      out_tag,
  output logic                               busy
);

  localparam int unsigned CNT_W = $clog2(RES_DEPTH) + 1;
  localparam int unsigned SUM_W = CNT_W + 1;

  logic [NUM_REQ-1:0][CNT_W-1:0] inflight;
  logic [NUM_REQ-1:0][CNT_W-1:0] fifo_count;
  logic [NUM_REQ-1:0]            eligible;
  logic [NUM_REQ-1:0]            cand;
  logic [NUM_REQ-1:0]            grant;
  logic                          grant_any;
  req_id_t                       grant_id;
  req_id_t                       rr_last;
  track_entry_t                  issue_entry_d;
  track_entry_t                  issue_entry;
  track_entry_t                  trk [PIPE_LAT];
  track_entry_t                  trk_out;
  logic [NUM_REQ-1:0]            push;

  // Credit check and round-robin pick; a tie goes to the requester not served last.
  always_comb begin
    eligible  = '0;
    cand      = '0;
    grant     = '0;
    grant_id  = 1'b0;
    grant_any = 1'b0;
    for (int r = 0; r < int'(NUM_REQ); r++) begin
      eligible[r] = (SUM_W'(inflight[r]) + SUM_W'(fifo_count[r])) < SUM_W'(RES_DEPTH);
      cand[r]     = req_valid[r] & eligible[r];
    end
    if (cand[0] && cand[1]) begin
      grant_id = ~rr_last;
    end else if (cand[1]) begin
      grant_id = 1'b1;
    end
    grant_any = (|cand) & ~rst;
    if (grant_any) begin
      grant[grant_id] = 1'b1;
    end
  end

  assign req_ready = grant;

  // Tracker entry for the op being accepted this cycle.
  always_comb begin
    issue_entry_d        = '0;
    issue_entry_d.valid  = grant_any;
    issue_entry_d.req_id = grant_id;
    issue_entry_d.tag    = TAG_W_DFLT'(req_tag[grant_id]);
  end

  // Issue register; SUB is sent as ADD with b's sign bit flipped.
  always_ff @(posedge clk) begin
    if (rst) begin
      issue_valid <= 1'b0;
      issue_a     <= '0;
      issue_b     <= '0;
      issue_entry <= '0;
      rr_last     <= 1'b1;
    end else begin
      issue_valid <= grant_any;
      issue_entry <= issue_entry_d;
      if (grant_any) begin
        issue_a <= req_a[grant_id];
        issue_b <= {req_b[grant_id][NUM_BITS-1] ^ req_sub[grant_id],
                    req_b[grant_id][NUM_BITS-2:0]};
        rr_last <= grant_id;
      end
    end
  end

  // Tracker shift register, loaded from the issue stage so its output lines up with res_data.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < int'(PIPE_LAT); i++) begin
        trk[i] <= '0;
      end
    end else begin
      trk[0] <= issue_entry;
      for (int i = 1; i < int'(PIPE_LAT); i++) begin
        trk[i] <= trk[i-1];
      end
    end
  end

  // Route the exiting op's result to its requester's FIFO.
  always_comb begin
    trk_out = trk[PIPE_LAT-1];
    push    = '0;
    if (trk_out.valid) begin
      push[trk_out.req_id] = 1'b1;
    end
  end

  // In-flight counters: +1 on accept, -1 when the result moves into the FIFO.
  always_ff @(posedge clk) begin
    if (rst) begin
      inflight <= '0;
    end else begin
      for (int r = 0; r < int'(NUM_REQ); r++) begin
        case ({grant[r], push[r]})
          2'b10:   inflight[r] <= inflight[r] + CNT_W'(1);
          2'b01:   inflight[r] <= inflight[r] - CNT_W'(1);
          default: inflight[r] <= inflight[r];
        endcase
      end
    end
  end

  always_comb begin
    busy = 1'b0;
    for (int r = 0; r < int'(NUM_REQ); r++) begin
      if ((inflight[r] != '0) || out_valid[r]) begin
        busy = 1'b1;
      end
    end
  end

  addsub_res_fifo #(
    .NUM_BITS  (NUM_BITS),
    .TAG_W     (TAG_W),
    .RES_DEPTH (RES_DEPTH)
  ) u_fifo0 (
    .clk       (clk),
    .rst       (rst),
    .push      (push[0]),
    .push_data (res_data),
    .push_tag  (TAG_W'(trk_out.tag)),
    .pop       (out_ready[0]),
    .valid     (out_valid[0]),
    .data      (out_data[0]),
    .tag       (out_tag[0]),
    .count     (fifo_count[0])
  );

  addsub_res_fifo #(
    .NUM_BITS  (NUM_BITS),
    .TAG_W     (TAG_W),
    .RES_DEPTH (RES_DEPTH)
  ) u_fifo1 (
    .clk       (clk),
    .rst       (rst),
    .push      (push[1]),
    .push_data (res_data),
    .push_tag  (TAG_W'(trk_out.tag)),
    .pop       (out_ready[1]),
    .valid     (out_valid[1]),
    .data      (out_data[1]),
    .tag       (out_tag[1]),
    .count     (fifo_count[1])
  );

endmodule

// File: tb/tb_addsub_issue_sched.sv
// Directed bench for addsub_issue_sched. The external pipeline is modelled
// as a PIPE_LAT-cycle delay line returning issue_a + issue_b (raw bit sum),
// so every expected result below is a hand-computed integer sum.
module tb_addsub_issue_sched;

  localparam int unsigned NUM_BITS  = 16;
  localparam int unsigned TAG_W     = 4;
  localparam int unsigned PIPE_LAT  = 3;
  localparam int unsigned RES_DEPTH = 4;

  logic                        clk;
  logic                        rst;
  logic [1:0]                  req_valid;
  logic [1:0]                  req_ready;
  logic [1:0][NUM_BITS-1:0]    req_a;
  logic [1:0][NUM_BITS-1:0]    req_b;
  logic [1:0]                  req_sub;
  logic [1:0][TAG_W-1:0]       req_tag;
  logic                        issue_valid;
  logic [NUM_BITS-1:0]         issue_a;
  logic [NUM_BITS-1:0]         issue_b;
  logic [NUM_BITS-1:0]         res_data;
  logic [1:0]                  out_valid;
  logic [1:0]                  out_ready;
  logic [1:0][NUM_BITS-1:0]    out_data;
  logic [1:0][TAG_W-1:0]       out_tag;
  logic                        busy;

  int n_cmp = 0;
  int n_err = 0;

  typedef struct {
    logic [15:0] d;
    logic [3:0]  t;
  } exp_t;

  exp_t exp0[$];
  exp_t exp1[$];

  addsub_issue_sched #(
    .NUM_BITS  (NUM_BITS),
    .TAG_W     (TAG_W),
    .PIPE_LAT  (PIPE_LAT),
    .RES_DEPTH (RES_DEPTH)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_a       (req_a),
    .req_b       (req_b),
    .req_sub     (req_sub),
    .req_tag     (req_tag),
    .issue_valid (issue_valid),
    .issue_a     (issue_a),
    .issue_b     (issue_b),
    .res_data    (res_data),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_data    (out_data),
    .out_tag     (out_tag),
    .busy        (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // External pipeline model: result valid PIPE_LAT cycles after issue_valid.
  logic [15:0] pipe_d [PIPE_LAT];
  logic        pipe_v [PIPE_LAT];
  always @(posedge clk) begin
    pipe_v[0] <= issue_valid;
    pipe_d[0] <= issue_a + issue_b;
    for (int i = 1; i < int'(PIPE_LAT); i++) begin
      pipe_v[i] <= pipe_v[i-1];
      pipe_d[i] <= pipe_d[i-1];
    end
  end
  assign res_data = (pipe_v[PIPE_LAT-1] === 1'b1) ? pipe_d[PIPE_LAT-1] : 16'hDEAD;

  // A push into a full FIFO must never happen.
  always @(negedge clk) begin
    if (rst === 1'b0) begin
      assert (!(dut.u_fifo0.push && dut.u_fifo0.count == 3'd4)) else begin
        n_err++;
        $error("FAIL fifo0_push_full observed=push_while_full expected=no_push");
      end
      assert (!(dut.u_fifo1.push && dut.u_fifo1.count == 3'd4)) else begin
        n_err++;
        $error("FAIL fifo1_push_full observed=push_while_full expected=no_push");
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  initial begin
    int n_acc;
    int idx0;
    int idx1;
    exp_t e;

    rst       = 1'b1;
    req_valid = '0;
    req_a     = '0;
    req_b     = '0;
    req_sub   = '0;
    req_tag   = '0;
    out_ready = '0;
    tick();
    tick();

    // Reset state
    chk("rst_issue_valid", 32'(issue_valid), 32'd0);
    chk("rst_issue_a", 32'(issue_a), 32'd0);
    chk("rst_issue_b", 32'(issue_b), 32'd0);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_data", 32'(out_data), 32'd0);
    chk("rst_out_tag", 32'(out_tag), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_req_ready", 32'(req_ready), 32'd0);
    rst = 1'b0;

    // Single ADD from r0: 0x3C00 + 0x4000 -> model 0x7C00, tag 5
    req_valid  = 2'b01;
    req_a[0]   = 16'h3C00;
    req_b[0]   = 16'h4000;
    req_sub[0] = 1'b0;
    req_tag[0] = 4'd5;
    #1;
    chk("add_ready", 32'(req_ready), 32'h1);
    tick();
    req_valid = 2'b00;
    chk("add_issue_valid", 32'(issue_valid), 32'd1);
    chk("add_issue_a", 32'(issue_a), 32'h3C00);
    chk("add_issue_b", 32'(issue_b), 32'h4000);
    chk("add_busy", 32'(busy), 32'd1);
    tick();
    chk("add_issue_idle", 32'(issue_valid), 32'd0);
    tick();
    tick();
    chk("add_not_early", 32'(out_valid), 32'd0);
    tick();
    chk("add_out_valid", 32'(out_valid), 32'h1);
    chk("add_out_data", 32'(out_data[0]), 32'h7C00);
    chk("add_out_tag", 32'(out_tag[0]), 32'd5);
    out_ready = 2'b01;
    tick();
    out_ready = 2'b00;
    chk("add_popped", 32'(out_valid), 32'd0);
    chk("add_idle_busy", 32'(busy), 32'd0);

    // SUB from r1: 0x4200 - 0x3C00 -> issue_b 0xBC00, model 0x4200+0xBC00 = 0xFE00
    req_valid  = 2'b10;
    req_a[1]   = 16'h4200;
    req_b[1]   = 16'h3C00;
    req_sub[1] = 1'b1;
    req_tag[1] = 4'd9;
    #1;
    chk("sub_ready", 32'(req_ready), 32'h2);
    tick();
    req_valid = 2'b00;
    chk("sub_issue_a", 32'(issue_a), 32'h4200);
    chk("sub_issue_b", 32'(issue_b), 32'hBC00);
    tick();
    tick();
    tick();
    tick();
    chk("sub_out_valid", 32'(out_valid), 32'h2);
    chk("sub_out_data", 32'(out_data[1]), 32'hFE00);
    chk("sub_out_tag", 32'(out_tag[1]), 32'd9);
    out_ready = 2'b10;
    tick();
    out_ready = 2'b00;

    // Tie: both requesters valid every cycle, grants alternate from r0 after reset
    do_reset();
    out_ready  = 2'b11;
    req_sub    = 2'b00;
    req_b[0]   = 16'h0001;
    req_b[1]   = 16'h0002;
    for (int i = 0; i < 4; i++) begin
      req_valid = 2'b11;
      req_a[0]  = 16'(i);
      req_a[1]  = 16'(i + 8);
      #1;
      chk("tie_grant", 32'(req_ready), (i % 2 == 0) ? 32'h1 : 32'h2);
      tick();
    end
    req_valid = 2'b00;
    repeat (8) tick();
    chk("tie_drained", 32'(busy), 32'd0);

    // Back-pressure: r0 streams with out_ready[0]=0, only RES_DEPTH accepts
    out_ready  = 2'b00;
    n_acc      = 0;
    req_b[0]   = 16'h0001;
    req_sub[0] = 1'b0;
    for (int c = 0; c < 12; c++) begin
      req_valid  = 2'b01;
      req_a[0]   = 16'h1000 + 16'(n_acc);
      req_tag[0] = 4'(n_acc);
      #1;
      if (req_ready[0]) begin
        e.d = 16'h1001 + 16'(n_acc);
        e.t = 4'(n_acc);
        exp0.push_back(e);
        n_acc++;
      end
      tick();
    end
    chk("bp_accepts", 32'(n_acc), 32'd4);
    chk("bp_ready0_low", 32'(req_ready[0]), 32'd0);

    // r1 still served while r0 is out of credit: 0x2000 - 0x0002 -> 0x2000+0x8002 = 0xA002
    req_valid  = 2'b11;
    req_a[1]   = 16'h2000;
    req_b[1]   = 16'h0002;
    req_sub[1] = 1'b1;
    req_tag[1] = 4'hA;
    #1;
    chk("bp_r1_served", 32'(req_ready), 32'h2);
    e.d = 16'hA002;
    e.t = 4'hA;
    exp1.push_back(e);
    tick();
    req_valid = 2'b01;
    repeat (6) tick();

    // Credit edge: FIFO0 full, nothing in flight; pop at T, credit usable at T+1
    out_ready = 2'b01;
    #1;
    chk("credit_at_pop", 32'(req_ready[0]), 32'd0);
    chk("credit_head_data", 32'(out_data[0]), 32'h1001);
    chk("credit_head_tag", 32'(out_tag[0]), 32'd0);
    idx0 = 1;
    idx1 = 0;
    tick();
    chk("credit_after_pop", 32'(req_ready[0]), 32'd1);
    e.d = 16'h1005;
    e.t = 4'd4;
    exp0.push_back(e);
    out_ready = 2'b11;

    // Drain both FIFOs, results in issue order per requester
    for (int it = 0; it < 20; it++) begin
      if (out_valid[0]) begin
        if (idx0 < exp0.size()) begin
          chk("drain0_data", 32'(out_data[0]), 32'(exp0[idx0].d));
          chk("drain0_tag", 32'(out_tag[0]), 32'(exp0[idx0].t));
        end else begin
          chk("drain0_extra", 32'(idx0), 32'(exp0.size()));
        end
        idx0++;
      end
      if (out_valid[1]) begin
        if (idx1 < exp1.size()) begin
          chk("drain1_data", 32'(out_data[1]), 32'(exp1[idx1].d));
          chk("drain1_tag", 32'(out_tag[1]), 32'(exp1[idx1].t));
        end else begin
          chk("drain1_extra", 32'(idx1), 32'(exp1.size()));
        end
        idx1++;
      end
      tick();
      req_valid = 2'b00;
    end
    chk("drain0_count", 32'(idx0), 32'd5);
    chk("drain1_count", 32'(idx1), 32'd1);
    chk("drain_busy", 32'(busy), 32'd0);

    // Reset with 3 ops in flight: nothing may complete afterwards
    out_ready  = 2'b00;
    req_b[0]   = 16'h0001;
    req_sub[0] = 1'b0;
    for (int i = 0; i < 3; i++) begin
      req_valid  = 2'b01;
      req_a[0]   = 16'h0500 + 16'(i);
      req_tag[0] = 4'(i);
      #1;
      chk("flight_accept", 32'(req_ready), 32'h1);
      tick();
    end
    req_valid = 2'b00;
    rst       = 1'b1;
    tick();
    rst = 1'b0;
    for (int i = 0; i < 8; i++) begin
      chk("post_rst_no_result", 32'(out_valid), 32'd0);
      tick();
    end
    chk("post_rst_busy", 32'(busy), 32'd0);

    // Next op after reset completes normally: 0x0100 + 0x0200 -> 0x0300
    req_valid  = 2'b10;
    req_a[1]   = 16'h0100;
    req_b[1]   = 16'h0200;
    req_sub[1] = 1'b0;
    req_tag[1] = 4'd3;
    #1;
    chk("post_rst_ready", 32'(req_ready), 32'h2);
    tick();
    req_valid = 2'b00;
    tick();
    tick();
    tick();
    chk("post_rst_not_early", 32'(out_valid), 32'd0);
    tick();
    chk("post_rst_out_valid", 32'(out_valid), 32'h2);
    chk("post_rst_out_data", 32'(out_data[1]), 32'h0300);
    chk("post_rst_out_tag", 32'(out_tag[1]), 32'd3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
